// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: widths, major opcodes, funct3 names and the
// op_class / alu_op encodings presented to execute.
package rv32i_pkg;

  localparam int XLEN  = 32;
  localparam int RAW   = 5;
  localparam int OPC_W = 4;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_ALT = 7'h20;

  // CLS_ILLEGAL marks an opcode outside the RV32I base set.
  typedef enum logic [OPC_W-1:0] {
    CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_BRANCH, CLS_LOAD,
    CLS_STORE, CLS_OPIMM, CLS_OP, CLS_FENCE, CLS_SYSTEM,
    CLS_ILLEGAL = 4'hF
  } op_class_e;

  typedef enum logic [OPC_W-1:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_e;

  // Register-register and register-immediate arithmetic share funct3; only OP has SUB.
  function automatic alu_op_e arith_alu(input logic [2:0] f3, input logic alt,
                                        input logic is_op);
    alu_op_e r;
    case (f3)
      F3_ADD:  r = (alt && is_op) ? ALU_SUB : ALU_ADD;
      F3_SLL:  r = ALU_SLL;
      F3_SLT:  r = ALU_SLT;
      F3_SLTU: r = ALU_SLTU;
      F3_XOR:  r = ALU_XOR;
      F3_SR:   r = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rv32i_imm_gen.sv
// Immediate generator: picks the I/S/B/U/J format from the decoded class and
// sign-extends it to XLEN. OP and unknown opcodes carry no immediate.
module rv32i_imm_gen
  import rv32i_pkg::*;
(
  input  logic [31:0]     instr,
  input  op_class_e       op_class,
  output logic [XLEN-1:0] imm
);

  always_comb begin
    imm = '0;
    case (op_class)
      CLS_LUI, CLS_AUIPC:
        imm = {instr[31:12], 12'h000};
      CLS_JAL:
        imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      CLS_JALR, CLS_LOAD, CLS_OPIMM, CLS_FENCE, CLS_SYSTEM:
        imm = {{20{instr[31]}}, instr[31:20]};
      CLS_STORE:
        imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      CLS_BRANCH:
        imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      default:
        imm = '0;
    endcase
  end

endmodule

// File: rtl/rv32i_decode_stage.sv
// RV32I decode stage: combinational field decode and register-file read request in
// the accept cycle, one registered decode bundle towards execute.
module rv32i_decode_stage
  import rv32i_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             if_valid,
  output logic             if_ready,
  input  logic [31:0]      if_instr,
  input  logic [XLEN-1:0]  if_pc,
  input  logic             flush,
  output logic [RAW-1:0]   rs1,
  output logic [RAW-1:0]   rs2,
  output logic             rs1_ren,
  output logic             rs2_ren,
  output logic             ex_valid,
  input  logic             ex_ready,
  output logic [XLEN-1:0]  ex_pc,
  output logic [RAW-1:0]   ex_rd,
  output logic             ex_rd_wen,
  output logic [XLEN-1:0]  ex_imm,
  output logic [OPC_W-1:0] ex_alu_op,
  output logic [OPC_W-1:0] ex_op_class,
  output logic [2:0]       ex_funct3,
  output logic             ex_illegal
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both high;
  // valid never depends on ready, and the producer holds its payload until transfer.
  logic       accept;
  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       uses_rs1, uses_rs2, has_rd, bad, illegal, rd_wen;
  op_class_e  cls;
  alu_op_e    alu;
  logic [XLEN-1:0] imm;

  assign opcode = if_instr[6:0];
  assign f3     = if_instr[14:12];
  assign f7     = if_instr[31:25];

  always_comb begin
    cls      = CLS_ILLEGAL;
    alu      = ALU_ADD;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    has_rd   = 1'b0;
    bad      = 1'b0;
    case (opcode)
      OPC_LUI:    begin cls = CLS_LUI; has_rd = 1'b1; alu = ALU_PASSB; end
      OPC_AUIPC:  begin cls = CLS_AUIPC; has_rd = 1'b1; end
      OPC_JAL:    begin cls = CLS_JAL; has_rd = 1'b1; end
      OPC_JALR:   begin
        cls = CLS_JALR; has_rd = 1'b1; uses_rs1 = 1'b1;
        bad = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        cls = CLS_BRANCH; uses_rs1 = 1'b1; uses_rs2 = 1'b1; alu = ALU_SUB;
        bad = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OPC_LOAD:   begin
        cls = CLS_LOAD; has_rd = 1'b1; uses_rs1 = 1'b1;
        bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_STORE:  begin
        cls = CLS_STORE; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        bad = (f3 >= 3'b011);
      end
      OPC_OPIMM:  begin
        cls = CLS_OPIMM; has_rd = 1'b1; uses_rs1 = 1'b1;
        alu = arith_alu(f3, f7[5], 1'b0);
        bad = ((f3 == F3_SLL) && (f7 != 7'h00)) ||
              ((f3 == F3_SR) && (f7 != 7'h00) && (f7 != F7_ALT));
      end
      OPC_OP:     begin
        cls = CLS_OP; has_rd = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        alu = arith_alu(f3, f7[5], 1'b1);
        bad = ((f7 != 7'h00) && (f7 != F7_ALT)) ||
              ((f7 == F7_ALT) && (f3 != F3_ADD) && (f3 != F3_SR));
      end
      OPC_FENCE:  cls = CLS_FENCE;
      OPC_SYSTEM: begin cls = CLS_SYSTEM; has_rd = 1'b1; end
      default:    bad = 1'b1;
    endcase
  end

  // Every listed opcode ends in 2'b11, but keep the compressed-quadrant test explicit.
  assign illegal  = bad | (if_instr[1:0] != 2'b11);
  assign rd_wen   = has_rd & (if_instr[11:7] != 5'd0) & ~illegal;

  assign if_ready = ~RST & ~flush & (~ex_valid | ex_ready);
  assign accept   = if_valid & if_ready;

  assign rs1      = if_instr[19:15];
  assign rs2      = if_instr[24:20];
  assign rs1_ren  = accept & uses_rs1 & ~illegal;
  assign rs2_ren  = accept & uses_rs2 & ~illegal;

  rv32i_imm_gen u_imm_gen (
    .instr    (if_instr),
    .op_class (cls),
    .imm      (imm)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rd       <= '0;
      ex_rd_wen   <= 1'b0;
      ex_imm      <= '0;
      ex_alu_op   <= '0;
      ex_op_class <= '0;
      ex_funct3   <= '0;
      ex_illegal  <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (accept) begin
      ex_valid    <= 1'b1;
      ex_pc       <= if_pc;
      ex_rd       <= if_instr[11:7];
      ex_rd_wen   <= rd_wen;
      ex_imm      <= imm;
      ex_alu_op   <= alu;
      ex_op_class <= cls;
      ex_funct3   <= f3;
      ex_illegal  <= illegal;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Bench for rv32i_decode_stage: directed vector table, hand-written handshake
// sequences, then randomized traffic against a rule-level decode model.
module tb_rv32i_decode_stage;
  import rv32i_pkg::*;

  logic        CLK, RST, if_valid, if_ready, flush, ex_ready;
  logic [31:0] if_instr, if_pc;
  logic [4:0]  rs1, rs2;
  logic        rs1_ren, rs2_ren, ex_valid;
  logic [31:0] ex_pc, ex_imm;
  logic [4:0]  ex_rd;
  logic        ex_rd_wen, ex_illegal;
  logic [3:0]  ex_alu_op, ex_op_class;
  logic [2:0]  ex_funct3;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        rd_wen;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic [3:0]  cls;
    logic [2:0]  f3;
    logic        ill;
  } bundle_t;
  localparam int BW = $bits(bundle_t);

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rs1, rs2;
    logic        r1, r2;
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] imm;
    logic [3:0]  alu, cls;
    logic [2:0]  f3;
    logic        ill;
  } vec_t;

  logic [BW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  logic [6:0] ops [11];

  rv32i_decode_stage dut (
    .CLK(CLK), .RST(RST), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .flush(flush),
    .rs1(rs1), .rs2(rs2), .rs1_ren(rs1_ren), .rs2_ren(rs2_ren),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_rd(ex_rd),
    .ex_rd_wen(ex_rd_wen), .ex_imm(ex_imm), .ex_alu_op(ex_alu_op),
    .ex_op_class(ex_op_class), .ex_funct3(ex_funct3), .ex_illegal(ex_illegal)
  );

  // ---------------- clock ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bundle_t dut_bundle();
    bundle_t b;
    b = {ex_pc, ex_rd, ex_rd_wen, ex_imm, ex_alu_op, ex_op_class, ex_funct3, ex_illegal};
    return b;
  endfunction

  function automatic logic [31:0] sext(input logic [31:0] v, input int n);
    return v[n-1] ? v - (32'h1 << n) : v;
  endfunction

  // Reference decode written from the ISA rules, independent of the RTL structure.
  function automatic bundle_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                         output logic r1, output logic r2);
    bundle_t b;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic u1, u2, hr, ill;
    logic [3:0] tbl [0:7];
    tbl = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    b = '0; b.pc = pc; b.rd = ins[11:7]; b.f3 = f3; b.alu = ALU_ADD;
    u1 = 0; u2 = 0; hr = 0; ill = 0;
    case (op)
      7'b0110111: begin b.cls = CLS_LUI; hr = 1; b.imm = ins & 32'hFFFF_F000; b.alu = ALU_PASSB; end
      7'b0010111: begin b.cls = CLS_AUIPC; hr = 1; b.imm = ins & 32'hFFFF_F000; end
      7'b1101111: begin
        b.cls = CLS_JAL; hr = 1;
        b.imm = sext({11'b0, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}, 21);
      end
      7'b1100111: begin b.cls = CLS_JALR; hr = 1; u1 = 1; ill = (f3 != 0); b.imm = sext(ins >> 20, 12); end
      7'b1100011: begin
        b.cls = CLS_BRANCH; u1 = 1; u2 = 1; b.alu = ALU_SUB; ill = (f3 == 2 || f3 == 3);
        b.imm = sext({19'b0, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}, 13);
      end
      7'b0000011: begin b.cls = CLS_LOAD; hr = 1; u1 = 1; ill = (f3 == 3 || f3 >= 6); b.imm = sext(ins >> 20, 12); end
      7'b0100011: begin
        b.cls = CLS_STORE; u1 = 1; u2 = 1; ill = (f3 >= 3);
        b.imm = sext({20'b0, ins[31:25], ins[11:7]}, 12);
      end
      7'b0010011: begin
        b.cls = CLS_OPIMM; hr = 1; u1 = 1; b.imm = sext(ins >> 20, 12);
        b.alu = (f3 == 5 && f7[5]) ? ALU_SRA : tbl[f3];
        ill = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 7'h20);
      end
      7'b0110011: begin
        b.cls = CLS_OP; hr = 1; u1 = 1; u2 = 1;
        b.alu = (f7[5] && f3 == 0) ? ALU_SUB : (f7[5] && f3 == 5) ? ALU_SRA : tbl[f3];
        ill = (f7 != 0 && f7 != 7'h20) || (f7 == 7'h20 && f3 != 0 && f3 != 5);
      end
      7'b0001111: begin b.cls = CLS_FENCE; b.imm = sext(ins >> 20, 12); end
      7'b1110011: begin b.cls = CLS_SYSTEM; hr = 1; b.imm = sext(ins >> 20, 12); end
      default:    begin b.cls = CLS_ILLEGAL; ill = 1; end
    endcase
    if (ins[1:0] != 2'b11) ill = 1;
    b.ill = ill;
    b.rd_wen = hr && (b.rd != 0) && !ill;
    r1 = u1 && !ill;
    r2 = u2 && !ill;
    return b;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic fl, input logic rdy);
    if_valid = v; if_instr = ins; if_pc = pc; flush = fl; ex_ready = rdy;
  endtask

  task automatic chk_front(input string name, input logic rdy, input logic [4:0] a,
                           input logic [4:0] b, input logic r1, input logic r2);
    chk({name, "_front"}, BW'({if_ready, rs1, rs2, rs1_ren, rs2_ren}), BW'({rdy, a, b, r1, r2}));
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] ins;
    int k;
    ins = $urandom();
    k = $urandom_range(0, 11);
    if (k < 11) ins[6:0] = ops[k];
    if ($urandom_range(0, 1) == 1) ins[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    if ($urandom_range(0, 15) == 0) ins[1:0] = 2'($urandom_range(0, 2));
    return ins;
  endfunction

  vec_t vecs [10];
  bundle_t eb, held;
  logic    r1, r2;

  initial begin
    ops = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
            OPC_STORE, OPC_OPIMM, OPC_OP, OPC_FENCE, OPC_SYSTEM};
    vecs[0] = '{32'hFFF08293, 1, 31, 1, 0, 5, 1, 32'hFFFF_FFFF, ALU_ADD, CLS_OPIMM, 0, 0};
    vecs[1] = '{32'h0021A423, 3, 2, 1, 1, 8, 0, 32'h8, ALU_ADD, CLS_STORE, 2, 0};
    vecs[2] = '{32'h123453B7, 8, 3, 0, 0, 7, 1, 32'h1234_5000, ALU_PASSB, CLS_LUI, 5, 0};
    vecs[3] = '{32'h00000000, 0, 0, 0, 0, 0, 0, 32'h0, ALU_ADD, CLS_ILLEGAL, 0, 1};
    vecs[4] = '{32'h00000033, 0, 0, 1, 1, 0, 0, 32'h0, ALU_ADD, CLS_OP, 0, 0};
    vecs[5] = '{32'h402081B3, 1, 2, 1, 1, 3, 1, 32'h0, ALU_SUB, CLS_OP, 0, 0};
    vecs[6] = '{32'hFE208EE3, 1, 2, 1, 1, 29, 0, 32'hFFFF_FFFC, ALU_SUB, CLS_BRANCH, 0, 0};
    vecs[7] = '{32'h008000EF, 0, 8, 0, 0, 1, 1, 32'h8, ALU_ADD, CLS_JAL, 0, 0};
    vecs[8] = '{32'h02000033, 0, 0, 0, 0, 0, 0, 32'h0, ALU_ADD, CLS_OP, 0, 1};
    vecs[9] = '{32'h4030D093, 1, 3, 1, 0, 1, 1, 32'h403, ALU_SRA, CLS_OPIMM, 5, 0};

    // ---------------- reset ----------------
    RST = 1'b1;
    drive(1'b1, 32'hFFF08293, 32'h0, 1'b0, 1'b1);
    repeat (2) @(negedge CLK);
    chk("reset_bundle", BW'({ex_valid, dut_bundle()}), '0);
    chk_front("reset", 0, 5'd1, 5'd31, 0, 0);
    RST = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    @(negedge CLK);

    // ---------------- directed vector table ----------------
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, vecs[i].instr, 32'h1000 + 32'(i * 4), 1'b0, 1'b1);
      #1;
      chk_front($sformatf("vec%0d", i), 1, vecs[i].rs1, vecs[i].rs2, vecs[i].r1, vecs[i].r2);
      @(negedge CLK);
      eb = {32'h1000 + 32'(i * 4), vecs[i].rd, vecs[i].wen, vecs[i].imm, vecs[i].alu,
            vecs[i].cls, vecs[i].f3, vecs[i].ill};
      chk($sformatf("vec%0d_bundle", i), BW'({ex_valid, dut_bundle()}), BW'({1'b1, eb}));
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    @(negedge CLK);
    chk("drain_valid", BW'(ex_valid), BW'(0));

    // ---------------- backpressure ----------------
    drive(1'b1, 32'hFFF08293, 32'h200, 1'b0, 1'b1);
    @(negedge CLK);
    held = ref_decode(32'hFFF08293, 32'h200, r1, r2);
    drive(1'b1, 32'h0021A423, 32'h204, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk_front($sformatf("stall%0d", c), 0, 5'd3, 5'd2, 0, 0);
      @(negedge CLK);
      chk($sformatf("stall%0d_hold", c), BW'({ex_valid, dut_bundle()}), BW'({1'b1, held}));
    end
    ex_ready = 1'b1;
    #1;
    chk_front("release", 1, 5'd3, 5'd2, 1, 1);
    @(negedge CLK);
    eb = ref_decode(32'h0021A423, 32'h204, r1, r2);
    chk("release_bundle", BW'({ex_valid, dut_bundle()}), BW'({1'b1, eb}));

    // ---------------- flush ----------------
    drive(1'b1, 32'h123453B7, 32'h208, 1'b1, 1'b0);
    #1;
    chk_front("flush", 0, 5'd8, 5'd3, 0, 0);
    @(negedge CLK);
    chk("flush_valid", BW'(ex_valid), BW'(0));
    chk("flush_hold", BW'(dut_bundle()), BW'(eb));

    // ---------------- reset mid-stream ----------------
    drive(1'b1, 32'h402081B3, 32'h300, 1'b0, 1'b1);
    @(negedge CLK);
    chk("pre_rst_valid", BW'(ex_valid), BW'(1));
    RST = 1'b1;
    drive(1'b1, 32'h0021A423, 32'h304, 1'b0, 1'b1);
    #1;
    chk_front("rst_mid", 0, 5'd3, 5'd2, 0, 0);
    @(negedge CLK);
    chk("rst_mid_bundle", BW'({ex_valid, dut_bundle()}), '0);
    RST = 1'b0;
    drive(1'b1, 32'h123453B7, 32'h308, 1'b0, 1'b1);
    #1;
    chk_front("post_rst", 1, 5'd8, 5'd3, 0, 0);
    @(negedge CLK);
    eb = ref_decode(32'h123453B7, 32'h308, r1, r2);
    chk("post_rst_bundle", BW'({ex_valid, dut_bundle()}), BW'({1'b1, eb}));
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    @(negedge CLK);

    // ---------------- randomized traffic with scoreboard ----------------
    exp_q.delete();
    for (int n = 0; n < 3000; n++) begin
      logic v, rdy, fl, exp_rdy, acc;
      logic [31:0] ins, pc;
      chk("rand_valid", BW'(ex_valid), BW'(exp_q.size() != 0));
      if (exp_q.size() != 0) chk("rand_bundle", BW'(dut_bundle()), exp_q[0]);
      v   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 15) == 0);
      ins = gen_instr();
      pc  = $urandom() & 32'hFFFF_FFFC;
      drive(v, ins, pc, fl, rdy);
      #1;
      exp_rdy = !fl && (exp_q.size() == 0 || rdy);
      acc = v && exp_rdy;
      eb = ref_decode(ins, pc, r1, r2);
      chk_front("rand", exp_rdy, ins[19:15], ins[24:20], acc && r1, acc && r2);
      if (fl) exp_q.delete();
      else if (acc) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        exp_q.push_back(BW'(eb));
      end else if (rdy && exp_q.size() != 0) void'(exp_q.pop_front());
      @(negedge CLK);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
